if_fetch: RTL and testbench
===========================

# if_fetch

Instruction fetch unit sitting between the PC register and the decode stage. It reads the current `pc_i` and issues single-outstanding requests to instruction memory. It returns `npc`/`pc_en` to the PC register to advance or redirect it. Fetched words are buffered in a small FIFO and delivered to decode under a valid/ready handshake.

## Interface
- `DEPTH`, 2: instruction FIFO entries (power of two, ≥2).
- `RESET_IDLE`, 1: cycles of forced idle after reset release; matches the PC register's post-reset hold cycle.

Ports. Reset `rst_n`, asynchronous, active-low; clock `clk`.
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous active-low reset
- `pc_i`  in  32  current PC from PC register
- `npc`  out  32  next PC to PC register
- `pc_en`  out  1  PC register load enable
- `redirect_valid`  in  1  branch/jump/exception redirect
- `redirect_target`  in  32  redirect address
- `imem_req`  out  1  fetch request
- `imem_addr`  out  32  fetch address (= `pc_i`)
- `imem_gnt`  in  1  request accepted this cycle
- `imem_rvalid`  in  1  read data valid (≥1 cycle after grant)
- `imem_rdata`  in  32  instruction word
- `inst_valid`  out  1  FIFO head valid
- `inst_pc`  out  32  PC of head instruction
- `inst`  out  32  head instruction
- `inst_ready`  in  1  decode accepts head

## Operation
- States: HOLD (post-reset), REQ (request driven), WAIT (granted, awaiting rvalid), DROP (granted request to be discarded).
- HOLD: lasts `RESET_IDLE` cycles after `rst_n` rises, then REQ.
- REQ: `imem_req`=1 only while `count + 0 < DEPTH`, i.e. a free FIFO slot exists; otherwise `imem_req`=0 and the unit stays in REQ. `imem_addr`=`pc_i`.
- On `imem_req && imem_gnt`: latch `pc_i` as the tag; `pc_en`=1, `npc`=`pc_i`+4 (mod 2^32, no alignment check); go to WAIT.
- WAIT: on `imem_rvalid`, push {tag, `imem_rdata`} into the FIFO, then go to REQ. FIFO space is guaranteed by the credit rule in REQ.
- DROP: on `imem_rvalid`, discard the data and go to REQ.
- Redirect (any state except HOLD):
  - `pc_en`=1, `npc`=`redirect_target`. This overrides the +4 path, including the same-cycle grant.
  - FIFO is flushed.
  - Any grant outstanding, or granted this cycle, sends the unit to DROP; otherwise the unit goes to REQ.
  - An `imem_rvalid` in the redirect cycle is discarded.
- FIFO pop on `inst_valid && inst_ready`; simultaneous push and pop keep `count` unchanged.
- `pc_en`=0 in all other cycles; `npc` holds its last value.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=`pc_i` (combinational), `pc_en`=0, `npc`=0, `inst_valid`=0, `inst_pc`=0, `inst`=0. State is HOLD and FIFO count is 0.
- `rst_n` low mid-transfer: state, FIFO and tag clear immediately. An `imem_rvalid` arriving after release is ignored, because HOLD does not accept data.
- Grant → PC updated at the next edge → next `imem_addr` reflects the new PC no earlier than 1 cycle after grant.
- `imem_rvalid` at cycle N → `inst_valid`=1 at N+1 (registered FIFO). Minimum fetch-to-decode latency is 2 cycles.
- Redirect at cycle N: `inst_valid`=0 at N+1. The first request to `redirect_target` is at N+1, or after the dropped rvalid if one is outstanding.
- Throughput: at most one instruction per 2 cycles with a 1-cycle memory (single outstanding).

## Configuration
- `IF_TRACE_EN`: when defined, adds output `fetch_cnt` [31:0]. It resets to 0, increments on each `inst_valid && inst_ready`, wraps at 2^32, and does not count dropped or flushed words. When undefined, the port and counter do not exist and behaviour is otherwise identical.

## Test plan
- Reset release, memory grants immediately with 1-cycle rvalid, `inst_ready`=1:
  - `imem_req` first at cycle `RESET_IDLE` after release, with `imem_addr`=0.
  - `npc` sequence 4, 8, 12.
  - `inst_pc` sequence 0, 4, 8.
  - One instruction every 2 cycles.
- `inst_ready`=0 for 10 cycles: exactly `DEPTH` (=2) words are fetched and `imem_req` drops. Raising `inst_ready` drains 0, 4, then fetch resumes at 8.
- Redirect to 0x100 while in WAIT for PC 0x8:
  - `pc_en`=1 with `npc`=0x100.
  - The 0x8 rvalid data is dropped.
  - The next delivered `inst_pc`=0x100.
- Redirect to 0x40 in the same cycle as a grant for 0x10: `npc`=0x40 (not 0x14), the 0x10 data is dropped, and the FIFO is flushed.
- `pc_i`=0xFFFFFFFC granted: `npc`=0x00000000 (wrap).
- `rst_n` pulsed low while in WAIT:
  - All outputs return to reset values within the reset cycle.
  - A late `imem_rvalid` during HOLD produces no `inst_valid`.
  - With `IF_TRACE_EN`, `fetch_cnt`=0.

Source files
------------

// File: rtl/if_fetch.sv
// if_fetch: single-outstanding instruction fetch feeding a small decode FIFO.
// Optional: define IF_TRACE_EN to add the fetch_cnt delivered-word counter.
module if_fetch #(
    parameter int DEPTH      = 2,
    parameter int RESET_IDLE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_i,
    output logic [31:0] npc,
    output logic        pc_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst_pc,
    output logic [31:0] inst,
    input  logic        inst_ready
`ifdef IF_TRACE_EN
    ,
    output logic [31:0] fetch_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int HW = (RESET_IDLE > 1) ? $clog2(RESET_IDLE) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_IDLE - 1);
    localparam logic [CW-1:0] CAP = CW'(DEPTH);

    typedef enum logic [1:0] {HOLD, REQ, WAIT, DROP} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } fifo_ent_t;

    state_t          state_q;
    state_t          state_d;
    logic [HW-1:0]   hold_q;
    logic [31:0]     tag_q;
    logic [31:0]     npc_q;
    logic [31:0]     npc_d;
    fifo_ent_t       fifo_q [DEPTH];
    logic [AW-1:0]   rd_q;
    logic [AW-1:0]   wr_q;
    logic [CW-1:0]   cnt_q;
    logic            grant;
    logic            redir;
    logic            pending;
    logic            push;
    logic            pop;

    // A request is only raised when the FIFO has room for its reply.
    assign imem_req   = (state_q == REQ) && (cnt_q < CAP);
    assign imem_addr  = pc_i;
    assign grant      = imem_req && imem_gnt;
    assign redir      = redirect_valid && (state_q != HOLD);
    assign pending    = ((state_q == WAIT) || (state_q == DROP)) && !imem_rvalid;
    assign inst_valid = (cnt_q != '0);
    assign pop        = inst_valid && inst_ready;
    assign inst_pc    = inst_valid ? fifo_q[rd_q].pc : '0;
    assign inst       = inst_valid ? fifo_q[rd_q].word : '0;
    assign npc        = npc_d;

    always_comb begin
        state_d = state_q;
        npc_d   = npc_q;
        pc_en   = 1'b0;
        push    = 1'b0;
        unique case (state_q)
            HOLD: if (hold_q == HOLD_LAST) state_d = REQ;
            REQ: begin
                if (grant) begin
                    pc_en   = 1'b1;
                    npc_d   = pc_i + 32'd4;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    push    = 1'b1;
                    state_d = REQ;
                end
            end
            DROP: if (imem_rvalid) state_d = REQ;
            default: state_d = HOLD;
        endcase
        // Redirect wins over the +4 path; any in-flight reply becomes stale.
        if (redir) begin
            pc_en   = 1'b1;
            npc_d   = redirect_target;
            push    = 1'b0;
            state_d = (grant || pending) ? DROP : REQ;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HOLD;
            hold_q  <= '0;
            tag_q   <= '0;
            npc_q   <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == HOLD) && (hold_q != HOLD_LAST))
                hold_q <= hold_q + HW'(1);
            if (grant)
                tag_q <= pc_i;
            if (pc_en)
                npc_q <= npc_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++)
                fifo_q[i] <= '0;
        end else if (redir) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_q] <= '{pc: tag_q, word: imem_rdata};
                wr_q         <= wr_q + AW'(1);
            end
            if (pop)
                rd_q <= rd_q + AW'(1);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

`ifdef IF_TRACE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            fetch_cnt <= '0;
        else if (pop)
            fetch_cnt <= fetch_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed scenarios plus a randomized run of if_fetch
// against a program-order reference model and a behavioural memory/PC.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_i;
    logic [31:0] npc;
    logic        pc_en;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst_pc;
    logic [31:0] inst;
    logic        inst_ready;
`ifdef IF_TRACE_EN
    logic [31:0] fetch_cnt;
`endif

    always #5 clk = ~clk;

    if_fetch #(.DEPTH(2), .RESET_IDLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .pc_i(pc_i), .npc(npc), .pc_en(pc_en),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst_pc(inst_pc), .inst(inst),
        .inst_ready(inst_ready)
`ifdef IF_TRACE_EN
        , .fetch_cnt(fetch_cnt)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    // behavioural memory: one pending reply, fixed word per address
    bit          mem_busy;
    logic [31:0] mem_addr;
    int          mem_wait;
    int          gnt_rate;
    int          lat_min;
    int          lat_max;

    logic        s_req, s_acc, s_rvalid, s_pc_en, s_valid, s_pop, s_redir;
    logic [31:0] s_addr, s_npc, s_ipc, s_inst, s_tgt;
    bit          s_overlap;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // One clock cycle: enter at posedge+2, sample at negedge.
    task automatic cycle();
        imem_gnt    = ($urandom_range(99) < gnt_rate);
        imem_rvalid = mem_busy && (mem_wait == 0);
        imem_rdata  = imem_rvalid ? word_of(mem_addr) : $urandom;
        #3;
        s_req     = imem_req;
        s_addr    = imem_addr;
        s_acc     = imem_req && imem_gnt;
        s_rvalid  = imem_rvalid;
        s_pc_en   = pc_en;
        s_npc     = npc;
        s_valid   = inst_valid;
        s_pop     = inst_valid && inst_ready;
        s_ipc     = inst_pc;
        s_inst    = inst;
        s_redir   = redirect_valid;
        s_tgt     = redirect_target;
        s_overlap = s_acc && mem_busy && !imem_rvalid;
        if (imem_rvalid) mem_busy = 1'b0;
        else if (mem_busy) mem_wait--;
        if (s_acc) begin
            mem_busy = 1'b1;
            mem_addr = imem_addr;
            mem_wait = int'($urandom_range(lat_max, lat_min)) - 1;
        end
        @(posedge clk);
        #1;
        if (!rst_n) pc_i = '0;
        else if (s_pc_en) pc_i = s_npc;
        cyc++;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        pc_i = '0;
        redirect_valid = 1'b0;
        redirect_target = '0;
        inst_ready = 1'b0;
        mem_busy = 1'b0;
        mem_wait = 0;
        gnt_rate = 100;
        lat_min = 1;
        lat_max = 1;
        cycle();
        cycle();
        rst_n = 1'b1;
        cyc = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        pc_i = '0;
        #1;
        n_cmp++;
        if ({imem_req, pc_en, inst_valid} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_ctl: got req/pc_en/valid=%b want 000",
                     {imem_req, pc_en, inst_valid});
        end
        n_cmp++;
        if (npc !== 32'h0) begin
            n_err++; $display("FAIL reset_npc: got %h want 0", npc);
        end
        n_cmp++;
        if ({inst_pc, inst} !== 64'h0) begin
            n_err++; $display("FAIL reset_inst: got %h/%h want 0/0", inst_pc, inst);
        end
        n_cmp++;
        if (imem_addr !== 32'h0) begin
            n_err++; $display("FAIL reset_addr: got %h want 0", imem_addr);
        end
    endtask

    task automatic test_fetch_seq();
        int first_req;
        logic [31:0] first_addr;
        logic [31:0] npcs[$];
        logic [31:0] pcs[$];
        int pcyc[$];
        logic [31:0] want;
        do_reset();
        inst_ready = 1'b1;
        first_req = -1;
        first_addr = '0;
        for (int i = 0; i < 10; i++) begin
            int c = cyc;
            cycle();
            if (s_req && first_req < 0) begin
                first_req = c;
                first_addr = s_addr;
            end
            if (s_pc_en) npcs.push_back(s_npc);
            if (s_pop) begin
                pcs.push_back(s_ipc);
                pcyc.push_back(c);
                n_cmp++;
                if (s_inst !== word_of(s_ipc)) begin
                    n_err++;
                    $display("FAIL seq_data: got %h want %h", s_inst, word_of(s_ipc));
                end
            end
        end
        n_cmp++;
        if (first_req != 1 || first_addr !== 32'h0) begin
            n_err++;
            $display("FAIL first_req: got cycle %0d addr %h want cycle 1 addr 0",
                     first_req, first_addr);
        end
        n_cmp++;
        if (npcs.size() < 3 || pcs.size() < 3) begin
            n_err++;
            $display("FAIL seq_len: got %0d npc / %0d inst want >=3 each",
                     npcs.size(), pcs.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                want = 32'(4 * (k + 1));
                n_cmp++;
                if (npcs[k] !== want) begin
                    n_err++; $display("FAIL seq_npc%0d: got %h want %h", k, npcs[k], want);
                end
                want = 32'(4 * k);
                n_cmp++;
                if (pcs[k] !== want) begin
                    n_err++; $display("FAIL seq_pc%0d: got %h want %h", k, pcs[k], want);
                end
            end
            for (int k = 1; k < 3; k++) begin
                n_cmp++;
                if (pcyc[k] - pcyc[k-1] != 2) begin
                    n_err++;
                    $display("FAIL seq_rate: got gap %0d want 2", pcyc[k] - pcyc[k-1]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int n_gnt;
        logic [31:0] pops[$];
        logic [31:0] accs[$];
        do_reset();
        n_gnt = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (s_acc) n_gnt++;
        end
        n_cmp++;
        if (n_gnt != 2 || s_req !== 1'b0) begin
            n_err++;
            $display("FAIL bp_fill: got %0d grants req=%b want 2 grants req=0", n_gnt, s_req);
        end
        inst_ready = 1'b1;
        for (int i = 0; i < 20 && pops.size() < 3; i++) begin
            cycle();
            if (s_pop) pops.push_back(s_ipc);
            if (s_acc) accs.push_back(s_addr);
        end
        n_cmp++;
        if (pops.size() < 3 || accs.size() < 1) begin
            n_err++;
            $display("FAIL bp_drain: got %0d pops %0d grants want >=3 / >=1",
                     pops.size(), accs.size());
        end else begin
            n_cmp++;
            if (pops[0] !== 32'h0 || pops[1] !== 32'h4 || pops[2] !== 32'h8) begin
                n_err++;
                $display("FAIL bp_order: got %h,%h,%h want 0,4,8", pops[0], pops[1], pops[2]);
            end
            n_cmp++;
            if (accs[0] !== 32'h8) begin
                n_err++; $display("FAIL bp_resume: got %h want 8", accs[0]);
            end
        end
    endtask

    task automatic test_redirect_wait();
        bit found;
        do_reset();
        inst_ready = 1'b1;
        lat_min = 3;
        lat_max = 3;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            cycle();
            if (s_acc && s_addr == 32'h8) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_err++; $display("FAIL rw_timeout: got no grant for 8 want grant");
        end
        redirect_valid = 1'b1;
        redirect_target = 32'h100;
        cycle();
        redirect_valid = 1'b0;
        n_cmp++;
        if (s_pc_en !== 1'b1 || s_npc !== 32'h100) begin
            n_err++; $display("FAIL rw_npc: got en=%b npc=%h want 1/100", s_pc_en, s_npc);
        end
        cycle();
        n_cmp++;
        if (s_valid !== 1'b0) begin
            n_err++; $display("FAIL rw_flush: got valid=%b want 0", s_valid);
        end
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            cycle();
            found = s_pop;
        end
        n_cmp++;
        if (!found || s_ipc !== 32'h100 || s_inst !== word_of(32'h100)) begin
            n_err++;
            $display("FAIL rw_next: got pop=%b pc=%h inst=%h want 1/100/%h",
                     found, s_ipc, s_inst, word_of(32'h100));
        end
    endtask

    task automatic test_redirect_grant();
        bit found;
        logic pre_valid;
        logic [31:0] pre_pc;
        do_reset();
        inst_ready = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (imem_req && imem_addr == 32'h10) begin
                found = 1'b1;
                break;
            end
            cycle();
        end
        pre_valid = inst_valid;
        pre_pc = inst_pc;
        n_cmp++;
        if (!found || pre_valid !== 1'b1 || pre_pc !== 32'hC) begin
            n_err++;
            $display("FAIL rg_setup: got found=%b valid=%b pc=%h want 1/1/c",
                     found, pre_valid, pre_pc);
        end
        redirect_valid = 1'b1;
        redirect_target = 32'h40;
        inst_ready = 1'b0;
        cycle();
        redirect_valid = 1'b0;
        inst_ready = 1'b1;
        n_cmp++;
        if (s_acc !== 1'b1 || s_pc_en !== 1'b1 || s_npc !== 32'h40) begin
            n_err++;
            $display("FAIL rg_npc: got gnt=%b en=%b npc=%h want 1/1/40", s_acc, s_pc_en, s_npc);
        end
        cycle();
        n_cmp++;
        if (s_valid !== 1'b0) begin
            n_err++; $display("FAIL rg_flush: got valid=%b want 0", s_valid);
        end
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            cycle();
            found = s_pop;
        end
        n_cmp++;
        if (!found || s_ipc !== 32'h40) begin
            n_err++; $display("FAIL rg_next: got pop=%b pc=%h want 1/40", found, s_ipc);
        end
    endtask

    task automatic test_wrap();
        bit found;
        redirect_valid = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        cycle();
        redirect_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            cycle();
            found = s_acc;
        end
        n_cmp++;
        if (!found || s_addr !== 32'hFFFF_FFFC || s_npc !== 32'h0) begin
            n_err++;
            $display("FAIL wrap_npc: got addr=%h npc=%h want fffffffc/0", s_addr, s_npc);
        end
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            cycle();
            found = s_pop;
        end
        n_cmp++;
        if (!found || s_ipc !== 32'hFFFF_FFFC) begin
            n_err++; $display("FAIL wrap_pc: got pop=%b pc=%h want 1/fffffffc", found, s_ipc);
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        do_reset();
        inst_ready = 1'b1;
        lat_min = 3;
        lat_max = 3;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            cycle();
            found = s_acc;
        end
        rst_n = 1'b0;
        pc_i = '0;
        #1;
        n_cmp++;
        if (!found || {imem_req, pc_en, inst_valid} !== 3'b000 || npc !== 32'h0 ||
            {inst_pc, inst} !== 64'h0) begin
            n_err++;
            $display("FAIL rm_outputs: got req=%b en=%b valid=%b npc=%h pc=%h inst=%h want all 0",
                     imem_req, pc_en, inst_valid, npc, inst_pc, inst);
        end
`ifdef IF_TRACE_EN
        n_cmp++;
        if (fetch_cnt !== 32'h0) begin
            n_err++; $display("FAIL rm_cnt: got %0d want 0", fetch_cnt);
        end
`endif
        cycle();
        cycle();
        rst_n = 1'b1;
        cycle();
        n_cmp++;
        if (s_valid !== 1'b0) begin
            n_err++; $display("FAIL rm_hold: got valid=%b want 0", s_valid);
        end
        cycle();
        n_cmp++;
        if (s_valid !== 1'b0) begin
            n_err++; $display("FAIL rm_late: got valid=%b want 0", s_valid);
        end
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            cycle();
            found = s_pop;
        end
        n_cmp++;
        if (!found || s_ipc !== 32'h0 || s_inst !== word_of(32'h0)) begin
            n_err++;
            $display("FAIL rm_resume: got pop=%b pc=%h inst=%h want 1/0/%h",
                     found, s_ipc, s_inst, word_of(32'h0));
        end
    endtask

    // Program-order model: deliveries run pc, pc+4, ... restarting at each redirect.
    task automatic test_random();
        logic [31:0] exp_next;
        logic [31:0] last_npc;
        logic [31:0] want;
        bit chk_flush;
        int pops;
        do_reset();
        gnt_rate = 60;
        lat_min = 1;
        lat_max = 4;
        exp_next = '0;
        last_npc = '0;
        chk_flush = 1'b0;
        pops = 0;
        for (int i = 0; i < 3000; i++) begin
            inst_ready = ($urandom_range(99) < 70);
            if (cyc >= 2 && $urandom_range(99) < 4) begin
                redirect_valid = 1'b1;
                redirect_target = $urandom & 32'hFFFF_FFFC;
            end else begin
                redirect_valid = 1'b0;
            end
            cycle();
            if (chk_flush) begin
                n_cmp++;
                if (s_valid !== 1'b0) begin
                    n_err++; $display("FAIL rnd_flush: got valid=%b want 0", s_valid);
                end
            end
            n_cmp++;
            if (s_overlap) begin
                n_err++; $display("FAIL rnd_outstanding: got 2 outstanding want 1");
            end
            n_cmp++;
            if (s_pc_en !== (s_acc || s_redir)) begin
                n_err++;
                $display("FAIL rnd_pc_en: got %b want %b", s_pc_en, s_acc || s_redir);
            end
            want = s_pc_en ? (s_redir ? s_tgt : s_addr + 32'd4) : last_npc;
            n_cmp++;
            if (s_npc !== want) begin
                n_err++; $display("FAIL rnd_npc: got %h want %h", s_npc, want);
            end
            last_npc = s_npc;
            if (s_pop) begin
                n_cmp++;
                if (s_ipc !== exp_next || s_inst !== word_of(exp_next)) begin
                    n_err++;
                    $display("FAIL rnd_inst: got %h/%h want %h/%h",
                             s_ipc, s_inst, exp_next, word_of(exp_next));
                end
                exp_next = s_ipc + 32'd4;
                pops++;
            end
            if (s_redir) exp_next = s_tgt;
            chk_flush = s_redir;
        end
        redirect_valid = 1'b0;
        n_cmp++;
        if (pops < 150) begin
            n_err++; $display("FAIL rnd_progress: got %0d deliveries want >=150", pops);
        end
`ifdef IF_TRACE_EN
        n_cmp++;
        if (fetch_cnt !== 32'(pops)) begin
            n_err++; $display("FAIL rnd_cnt: got %0d want %0d", fetch_cnt, pops);
        end
`endif
    endtask

    initial begin
        rst_n = 1'b0;
        pc_i = '0;
        redirect_valid = 1'b0;
        redirect_target = '0;
        inst_ready = 1'b0;
        imem_gnt = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata = '0;
        mem_busy = 1'b0;
        mem_wait = 0;
        gnt_rate = 100;
        lat_min = 1;
        lat_max = 1;
        @(posedge clk);
        #2;
        test_reset();
        test_fetch_seq();
        test_backpressure();
        test_redirect_wait();
        test_redirect_grant();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
